// File: rtl/hilo_muldiv_ctrl.sv
// ---------------------------------------------------------------------------
// hilo_muldiv_ctrl
//   HI/LO register pair with an iterative radix-2 multiply/divide engine.
//   MULT/MULTU/DIV/DIVU take 32 cycles (one step per cycle); MTHI/MTLO write
//   directly. A divide by zero completes at once with hi=dividend, lo=all ones.
//
//   Optional feature: define HILO_FAST_MUL_EN to make MULT/MULTU complete in a
//   single cycle (MUL state unused); division stays iterative.
//
// Ports
//   i_clk        clock, rising edge
//   i_rst        synchronous active-high reset
//   i_start      request strobe, only sampled in IDLE
//   i_op[2:0]    0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6-7 no-op
//   i_src_a      multiplicand / dividend / MTHI-MTLO data
//   i_src_b      multiplier / divisor
//   i_cancel     pipeline flush: aborts an operation in flight, beats start
//   o_busy       high while in MUL or DIV (derived from the state register)
//   o_done       one-cycle pulse when a MULT/DIV result lands in hi/lo
//   o_hi, o_lo   HI and LO registers
//   o_state      current FSM state (0 IDLE, 1 MUL, 2 DIV) for observation
//
// Handshake: a request is accepted on an edge where the FSM is IDLE, i_start
// is high and i_cancel is low. The requester holds i_start until o_busy is
// low; starts seen while busy are ignored.
// ---------------------------------------------------------------------------
module hilo_muldiv_ctrl (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    input  logic [2:0]  i_op,
    input  logic [31:0] i_src_a,
    input  logic [31:0] i_src_b,
    input  logic        i_cancel,
    output logic        o_busy,
    output logic        o_done,
    output logic [31:0] o_hi,
    output logic [31:0] o_lo,
    output logic [1:0]  o_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic [5:0]  r_cnt;
    logic [63:0] r_acc;     // mul: {partial product, multiplier}; div: {remainder, quotient}
    logic [31:0] r_opb;     // mul: multiplicand magnitude; div: divisor magnitude
    logic        r_neg_q;   // negate product / quotient at the end
    logic        r_neg_r;   // negate remainder at the end
    logic        r_done;
    logic [31:0] r_hi;
    logic [31:0] r_lo;

    logic        w_req;
    logic        w_is_mul;
    logic        w_is_div;
    logic        w_signed;
    logic        w_div0;
    logic        w_last;
    logic [31:0] w_abs_a;
    logic [31:0] w_abs_b;
    logic [32:0] w_mul_sum;
    logic [32:0] w_div_rem;
    logic        w_div_ge;
    logic [32:0] w_div_sub;
    logic [63:0] w_step_acc;
    logic [63:0] w_prod_fix;
    logic [31:0] w_quo_fix;
    logic [31:0] w_rem_fix;

    // Cancel beats a coinciding start in IDLE.
    assign w_req    = (r_state == S_IDLE) && i_start && !i_cancel;
    assign w_is_mul = (i_op == 3'd0) || (i_op == 3'd1);
    assign w_is_div = (i_op == 3'd2) || (i_op == 3'd3);
    assign w_signed = (i_op == 3'd0) || (i_op == 3'd2);
    assign w_div0   = w_is_div && (i_src_b == 32'd0);
    assign w_last   = (r_cnt == 6'd31);

    assign w_abs_a = (w_signed && i_src_a[31]) ? (~i_src_a + 32'd1) : i_src_a;
    assign w_abs_b = (w_signed && i_src_b[31]) ? (~i_src_b + 32'd1) : i_src_b;

    // Multiply step: add multiplicand when the low multiplier bit is set,
    // then shift the whole accumulator right by one.
    assign w_mul_sum = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_opb} : 33'd0);

    // Restoring divide step: shift the next dividend bit into the remainder,
    // subtract the divisor when it fits; the 33-bit remainder never exceeds
    // 2*divisor-1, so the difference fits back into 32 bits.
    assign w_div_rem = {r_acc[63:31]};
    assign w_div_ge  = (w_div_rem >= {1'b0, r_opb});
    assign w_div_sub = w_div_ge ? (w_div_rem - {1'b0, r_opb}) : w_div_rem;

    assign w_step_acc = (r_state == S_DIV) ? {w_div_sub[31:0], r_acc[30:0], w_div_ge}
                                           : {w_mul_sum, r_acc[31:1]};

    assign w_prod_fix = r_neg_q ? (~w_step_acc + 64'd1) : w_step_acc;
    assign w_quo_fix  = r_neg_q ? (~w_step_acc[31:0] + 32'd1) : w_step_acc[31:0];
    assign w_rem_fix  = r_neg_r ? (~w_step_acc[63:32] + 32'd1) : w_step_acc[63:32];

`ifdef HILO_FAST_MUL_EN
    logic [63:0] w_fast_prod;
    assign w_fast_prod = w_signed
        ? 64'($signed({{32{i_src_a[31]}}, i_src_a}) * $signed({{32{i_src_b[31]}}, i_src_b}))
        : 64'({32'd0, i_src_a} * {32'd0, i_src_b});
`endif

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_next_state;
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
`ifndef HILO_FAST_MUL_EN
                if (w_req && w_is_mul) w_next_state = S_MUL;
`endif
                if (w_req && w_is_div && !w_div0) w_next_state = S_DIV;
            end
            S_MUL, S_DIV: begin
                if (i_cancel || w_last) w_next_state = S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // Datapath and HI/LO registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt   <= 6'd0;
            r_acc   <= 64'd0;
            r_opb   <= 32'd0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_done  <= 1'b0;
            r_hi    <= 32'd0;
            r_lo    <= 32'd0;
        end else begin
            r_done <= 1'b0;
            if (r_state == S_IDLE) begin
                if (w_req) begin
                    if (w_is_mul) begin
`ifdef HILO_FAST_MUL_EN
                        r_hi   <= w_fast_prod[63:32];
                        r_lo   <= w_fast_prod[31:0];
                        r_done <= 1'b1;
`else
                        r_acc   <= {32'd0, w_abs_b};
                        r_opb   <= w_abs_a;
                        r_neg_q <= w_signed && (i_src_a[31] ^ i_src_b[31]);
                        r_cnt   <= 6'd0;
`endif
                    end else if (w_is_div) begin
                        if (w_div0) begin
                            r_hi   <= i_src_a;
                            r_lo   <= 32'hFFFF_FFFF;
                            r_done <= 1'b1;
                        end else begin
                            r_acc   <= {32'd0, w_abs_a};
                            r_opb   <= w_abs_b;
                            r_neg_q <= w_signed && (i_src_a[31] ^ i_src_b[31]);
                            r_neg_r <= w_signed && i_src_a[31];
                            r_cnt   <= 6'd0;
                        end
                    end else if (i_op == 3'd4) begin
                        r_hi <= i_src_a;
                    end else if (i_op == 3'd5) begin
                        r_lo <= i_src_a;
                    end
                end
            end else if (!i_cancel) begin
                r_acc <= w_step_acc;
                r_cnt <= r_cnt + 6'd1;
                if (w_last) begin
                    r_done <= 1'b1;
                    if (r_state == S_DIV) begin
                        r_hi <= w_rem_fix;
                        r_lo <= w_quo_fix;
                    end else begin
                        r_hi <= w_prod_fix[63:32];
                        r_lo <= w_prod_fix[31:0];
                    end
                end
            end
        end
    end

    assign o_busy  = (r_state != S_IDLE);
    assign o_done  = r_done;
    assign o_hi    = r_hi;
    assign o_lo    = r_lo;
    assign o_state = r_state;

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hilo_muldiv_ctrl
//   Directed-vector bench for hilo_muldiv_ctrl with hand-computed results.
//   Inputs change and outputs are sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_hilo_muldiv_ctrl;

    logic        clk;
    logic        rst;
    logic        start;
    logic [2:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        cancel;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [1:0]  state;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef HILO_FAST_MUL_EN
    localparam int MUL_BUSY = 0;
`else
    localparam int MUL_BUSY = 32;
`endif

    hilo_muldiv_ctrl dut (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_start  (start),
        .i_op     (op),
        .i_src_a  (src_a),
        .i_src_b  (src_b),
        .i_cancel (cancel),
        .o_busy   (busy),
        .o_done   (done),
        .o_hi     (hi),
        .o_lo     (lo),
        .o_state  (state)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle: across the rising edge to the next falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Issue one request, count busy cycles, then check the done pulse and result.
    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input int exp_busy,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int n;
        int early_done;
        start = 1'b1; op = o; src_a = a; src_b = b;
        tick();
        start = 1'b0;
        n = 0;
        early_done = 0;
        while (busy && n < 100) begin
            if (done) early_done++;
            tick();
            n++;
        end
        check({tag, "_busy_cycles"}, 64'(n), 64'(exp_busy));
        check({tag, "_done_early"}, 64'(early_done), 64'd0);
        check({tag, "_done"}, {63'd0, done}, 64'd1);
        check({tag, "_hi"}, {32'd0, hi}, {32'd0, exp_hi});
        check({tag, "_lo"}, {32'd0, lo}, {32'd0, exp_lo});
        tick();
        check({tag, "_done_clear"}, {63'd0, done}, 64'd0);
    endtask

    task automatic write_hilo(input logic [31:0] h, input logic [31:0] l);
        start = 1'b1; op = 3'd4; src_a = h;
        tick();
        op = 3'd5; src_a = l;
        tick();
        start = 1'b0;
    endtask

    initial begin
        int dn;
        rst = 1'b1; start = 1'b0; op = 3'd0; src_a = 32'd0; src_b = 32'd0; cancel = 1'b0;
        repeat (3) tick();

        // Reset state, with start and cancel also asserted under reset
        start = 1'b1; cancel = 1'b1; op = 3'd4; src_a = 32'hDEAD_BEEF;
        tick();
        start = 1'b0; cancel = 1'b0;
        check("rst_busy",  {63'd0, busy}, 64'd0);
        check("rst_done",  {63'd0, done}, 64'd0);
        check("rst_hi",    {32'd0, hi}, 64'd0);
        check("rst_lo",    {32'd0, lo}, 64'd0);
        check("rst_state", {62'd0, state}, 64'd0);
        rst = 1'b0;
        tick();

        // Multiply / divide vectors
        run_op("mult_neg2x3",  3'd0, 32'hFFFF_FFFE, 32'd3, MUL_BUSY, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
        run_op("multu_neg2x3", 3'd1, 32'hFFFF_FFFE, 32'd3, MUL_BUSY, 32'h0000_0002, 32'hFFFF_FFFA);
        run_op("mult_m5xm7",   3'd0, 32'hFFFF_FFFB, 32'hFFFF_FFF9, MUL_BUSY, 32'd0, 32'd35);
        run_op("mult_min_sq",  3'd0, 32'h8000_0000, 32'h8000_0000, MUL_BUSY, 32'h4000_0000, 32'd0);
        run_op("multu_max_sq", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_BUSY, 32'hFFFF_FFFE, 32'd1);
        run_op("div_m7by2",    3'd2, 32'hFFFF_FFF9, 32'd2, 32, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("div_7bym2",    3'd2, 32'd7, 32'hFFFF_FFFE, 32, 32'd1, 32'hFFFF_FFFD);
        run_op("div_min_bym1", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32, 32'd0, 32'h8000_0000);
        run_op("divu_100by7",  3'd3, 32'd100, 32'd7, 32, 32'd2, 32'd14);
        run_op("divu_big",     3'd3, 32'hFFFF_FFF9, 32'd2, 32, 32'd1, 32'h7FFF_FFFC);
        run_op("divu_by0",     3'd3, 32'd100, 32'd0, 0, 32'd100, 32'hFFFF_FFFF);
        run_op("div_by0",      3'd2, 32'hFFFF_FFF0, 32'd0, 0, 32'hFFFF_FFF0, 32'hFFFF_FFFF);

        // MTHI then MTLO back-to-back
        start = 1'b1; op = 3'd4; src_a = 32'h1234_5678;
        tick();
        check("mthi_hi",   {32'd0, hi}, 64'h1234_5678);
        check("mthi_done", {63'd0, done}, 64'd0);
        check("mthi_busy", {63'd0, busy}, 64'd0);
        op = 3'd5; src_a = 32'h9ABC_DEF0;
        tick();
        start = 1'b0;
        check("mtlo_lo",   {32'd0, lo}, 64'h9ABC_DEF0);
        check("mtlo_hi",   {32'd0, hi}, 64'h1234_5678);
        check("mtlo_done", {63'd0, done}, 64'd0);

        // No-op opcodes
        start = 1'b1; op = 3'd6; src_a = 32'h5555_5555; src_b = 32'h1;
        tick();
        op = 3'd7;
        tick();
        start = 1'b0;
        check("nop_hi",   {32'd0, hi}, 64'h1234_5678);
        check("nop_lo",   {32'd0, lo}, 64'h9ABC_DEF0);
        check("nop_busy", {63'd0, busy}, 64'd0);
        check("nop_done", {63'd0, done}, 64'd0);

        // Cancel and start together in IDLE: cancel wins
        start = 1'b1; cancel = 1'b1; op = 3'd4; src_a = 32'hAAAA_AAAA;
        tick();
        op = 3'd2; src_a = 32'd50; src_b = 32'd5;
        tick();
        start = 1'b0; cancel = 1'b0;
        check("idle_cancel_busy", {63'd0, busy}, 64'd0);
        check("idle_cancel_hi",   {32'd0, hi}, 64'h1234_5678);
        check("idle_cancel_lo",   {32'd0, lo}, 64'h9ABC_DEF0);

        // Cancel a DIV in cycle E+10, with a coinciding start
        start = 1'b1; op = 3'd2; src_a = 32'd1000; src_b = 32'd3;
        tick();
        start = 1'b0;
        repeat (9) tick();
        check("cancel_busy_before", {63'd0, busy}, 64'd1);
        cancel = 1'b1; start = 1'b1; op = 3'd0; src_a = 32'd9; src_b = 32'd9;
        tick();
        cancel = 1'b0; start = 1'b0;
        check("cancel_busy_after", {63'd0, busy}, 64'd0);
        dn = 0;
        for (int i = 0; i < 40; i++) begin
            if (done || busy) dn++;
            tick();
        end
        check("cancel_no_done", 64'(dn), 64'd0);
        check("cancel_hi", {32'd0, hi}, 64'h1234_5678);
        check("cancel_lo", {32'd0, lo}, 64'h9ABC_DEF0);

        // Cancel on the final step edge (cycle E+32)
        start = 1'b1; op = 3'd3; src_a = 32'd77; src_b = 32'd4;
        tick();
        start = 1'b0;
        repeat (31) tick();
        check("late_cancel_busy_before", {63'd0, busy}, 64'd1);
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        check("late_cancel_busy", {63'd0, busy}, 64'd0);
        check("late_cancel_done", {63'd0, done}, 64'd0);
        check("late_cancel_hi",   {32'd0, hi}, 64'h1234_5678);
        check("late_cancel_lo",   {32'd0, lo}, 64'h9ABC_DEF0);

        // Start MULT while a DIVU is in progress: ignored
        start = 1'b1; op = 3'd3; src_a = 32'd100; src_b = 32'd7;
        tick();
        op = 3'd0; src_a = 32'd3; src_b = 32'd3;
        repeat (5) tick();
        start = 1'b0;
        repeat (26) tick();
        check("overlap_busy_e32", {63'd0, busy}, 64'd1);
        tick();
        check("overlap_busy_e33", {63'd0, busy}, 64'd0);
        check("overlap_done",     {63'd0, done}, 64'd1);
        check("overlap_hi",       {32'd0, hi}, 64'd2);
        check("overlap_lo",       {32'd0, lo}, 64'd14);
        tick();
        check("overlap_idle_busy", {63'd0, busy}, 64'd0);

        // Reset in cycle E+20 of a MULT
        write_hilo(32'h0F0F_0F0F, 32'hF0F0_F0F0);
        start = 1'b1; op = 3'd0; src_a = 32'd123; src_b = 32'd456;
        tick();
        start = 1'b0;
        repeat (19) tick();
        rst = 1'b1;
        tick();
        check("midrst_busy", {63'd0, busy}, 64'd0);
        check("midrst_done", {63'd0, done}, 64'd0);
        check("midrst_hi",   {32'd0, hi}, 64'd0);
        check("midrst_lo",   {32'd0, lo}, 64'd0);
        rst = 1'b0;
        repeat (40) tick();
        check("midrst_hi_after", {32'd0, hi}, 64'd0);
        check("midrst_lo_after", {32'd0, lo}, 64'd0);

        // Machine still works after the reset
        run_op("post_rst_multu", 3'd1, 32'd123, 32'd456, MUL_BUSY, 32'd0, 32'd56088);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hilo_muldiv_ctrl.md
HILO_MULDIV_CTRL -- requirements
Module: hilo_muldiv_ctrl

Interface
REQ-001 clk  in  1  sole clock; all state updates on rising edge.
REQ-002 rst  in  1  reset, synchronous, active-high.
REQ-003 start  in  1  request strobe; sampled only in IDLE.
REQ-004 op  in  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6-7 no-op.
REQ-005 src_a  in  32  rs operand: multiplicand, dividend, or MTHI/MTLO data.
REQ-006 src_b  in  32  rt operand: multiplier or divisor.
REQ-007 cancel  in  1  pipeline flush; aborts an operation in flight.
REQ-008 busy  out  1  registered; high while in MUL or DIV; pipeline stalls HI/LO readers on it.
REQ-009 done  out  1  one-cycle pulse when a MULT/DIV result lands in hi/lo.
REQ-010 hi  out  32  HI register.
REQ-011 lo  out  32  LO register.

Function
REQ-012 States SHALL be IDLE, MUL, DIV; busy = (state != IDLE).
REQ-013 IDLE & start & op in {0,1} SHALL load operands, clear 6-bit iteration counter, go to MUL at the same edge (edge E).
REQ-014 IDLE & start & op in {2,3} & src_b != 0 SHALL go to DIV at edge E.
REQ-015 MUL/DIV SHALL perform one radix-2 step per cycle; on the 32nd step edge (E+32), write {hi,lo}, pulse done for the following cycle, return to IDLE.
REQ-016 busy SHALL be 1 for exactly cycles E+1..E+32; done SHALL be 1 only in cycle E+33, with hi/lo valid from that cycle.
REQ-017 MULT SHALL produce the signed 64-bit product, MULTU the unsigned one; hi = product[63:32], lo = product[31:0].
REQ-018 DIV SHALL use magnitudes, then fix signs: quotient negated when operand signs differ, remainder takes dividend sign; lo = quotient, hi = remainder; DIVU unsigned.
REQ-019 DIV of 0x80000000 by 0xFFFFFFFF SHALL give lo = 0x80000000, hi = 0.
REQ-020 Divide by zero (op 2/3, src_b == 0) SHALL not enter DIV; at edge E hi <= src_a, lo <= 0xFFFFFFFF, done pulses in cycle E+1, busy stays 0.
REQ-021 IDLE & start & op 4 SHALL write hi <= src_a at edge E; op 5 writes lo; no done pulse, no state change.
REQ-022 IDLE & start & op 6/7 SHALL have no effect.
REQ-023 start while busy SHALL be ignored; requester holds start until busy is low.
REQ-024 cancel in MUL/DIV SHALL return to IDLE next edge, leave hi/lo unchanged, suppress done.
REQ-025 cancel & start in IDLE same cycle: cancel SHALL win; request dropped, hi/lo unchanged.
REQ-026 cancel coinciding with the 32nd step edge SHALL win: no write, no done.
REQ-027 hi/lo SHALL change only per REQ-015/020/021.

Reset
REQ-028 rst SHALL force state IDLE, busy 0, done 0, hi 0, lo 0, counter 0, overriding start and cancel.
REQ-029 rst mid-operation SHALL discard the operation without writing hi/lo beyond the reset value.

Configuration
REQ-030 Macro HILO_FAST_MUL_EN defined: MULT/MULTU SHALL complete single-cycle, writing hi/lo at edge E, done in cycle E+1, busy never asserted, MUL state unused; DIV unaffected.
REQ-031 HILO_FAST_MUL_EN undefined: MULT/MULTU SHALL use the 32-step iterative path of REQ-015/016.

Verification
REQ-032 MULT src_a=0xFFFFFFFE, src_b=3 -> done at E+33 (E+1 fast), hi=0xFFFFFFFF, lo=0xFFFFFFFA; MULTU same operands -> hi=0x2, lo=0xFFFFFFFA.
REQ-033 DIV src_a=0xFFFFFFF9 (-7), src_b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF, busy exactly 32 cycles.
REQ-034 DIVU src_a=100, src_b=0 -> cycle E+1: hi=100, lo=0xFFFFFFFF, done=1, busy never 1.
REQ-035 DIV started, cancel at cycle E+10 -> busy low from E+11, no done, hi/lo retain prior values; a start in the same cycle as cancel is dropped.
REQ-036 MTHI 0x12345678 then MTLO 0x9ABCDEF0 back-to-back -> hi/lo updated at each edge, done stays 0; start MULT during a DIV in progress -> ignored, DIV result intact.
REQ-037 rst asserted at cycle E+20 of MULT -> next cycle busy=0, done=0, hi=lo=0.
